// File: rtl/async_fifo_pkg.sv
// Shared helpers for the FIFOGEN asynchronous FIFO controllers (read and write side).
package async_fifo_pkg;

  // Widest pointer the helpers handle; callers zero-extend in and truncate out.
  localparam int unsigned PTR_MAX_W = 16;

  localparam int unsigned OBUF_DEPTH = 2;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_rd_ctrl_if.sv
// RAM read port plus the valid/ready output stream of the FIFO read controller.
interface async_fifo_rd_ctrl_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 32
) ();

  logic          ram_re;
  logic [AW-1:0] ram_ra;
  logic [DW-1:0] ram_dout;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;

  modport master (
    output ram_re,
    output ram_ra,
    input  ram_dout,
    output rd_pvld,
    input  rd_prdy,
    output rd_pd
  );

  modport slave (
    input  ram_re,
    input  ram_ra,
    output ram_dout,
    input  rd_pvld,
    output rd_prdy,
    input  rd_pd
  );

endinterface

// File: rtl/async_fifo_sync2.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
module async_fifo_sync2 #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  (* dont_touch = "true", async_reg = "true" *) logic [Width-1:0] sync1_q;
  (* dont_touch = "true", async_reg = "true" *) logic [Width-1:0] sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: pointer sync, RAM read issue,
// 2-entry output buffer, idle detection and read-domain clock-gate enable.
module async_fifo_rd_ctrl
  import async_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = 4,
  parameter int unsigned DW        = 32,
  parameter int unsigned IDLE_HOLD = 4
) (
  input  logic                 rd_clk,
  input  logic                 rd_reset,
  input  logic [AW:0]          wr_ptr_gray,
  input  logic                 enable_r,
  async_fifo_rd_ctrl_if.master rd_bus,
  output logic [AW:0]          rd_ptr_gray,
  output logic [AW:0]          rd_count,
  output logic                 rd_idle,
  output logic                 rd_clk_en
);

  if (DEPTH != (32'd1 << AW) || DEPTH < 4 || IDLE_HOLD < 1 || IDLE_HOLD > 15)
  begin : g_param_check
    $error("async_fifo_rd_ctrl: inconsistent DEPTH/AW or IDLE_HOLD out of range");
  end

  localparam logic [3:0] HoldCnt = 4'(IDLE_HOLD);

  logic [AW:0]   sync2;
  logic [AW:0]   wr_bin;
  logic [AW:0]   rd_bin_q, rd_bin_d;
  logic [AW:0]   rd_ptr_gray_q;
  logic          inflight_q;
  logic [1:0]    occ_q, occ_d;
  logic [DW-1:0] head_q, tail_q;
  logic [3:0]    idle_cnt_q, idle_cnt_d;
  logic          rd_idle_q;
  logic          empty, pop, ram_re, pvld, idle_cond;
  logic [2:0]    level;

  async_fifo_sync2 #(
    .Width(AW + 1)
  ) u_wr_ptr_sync (
    .clk_i(rd_clk),
    .rst_i(rd_reset),
    .d_i  (wr_ptr_gray),
    .q_o  (sync2)
  );

  assign wr_bin   = (AW+1)'(gray2bin(PTR_MAX_W'(sync2)));
  assign rd_count = wr_bin - rd_bin_q;
  assign empty    = (rd_count == '0);

  assign pvld  = (occ_q != 2'd0);
  assign pop   = pvld & rd_bus.rd_prdy;
  // Entries buffered plus in flight after this cycle's pop; must stay below the buffer depth.
  assign level = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
  assign ram_re = enable_r & ~empty & (level < 3'(OBUF_DEPTH));

  assign rd_bin_d = ram_re ? rd_bin_q + (AW+1)'(1) : rd_bin_q;
  assign occ_d    = occ_q + 2'(inflight_q) - 2'(pop);

  assign idle_cond = empty & (occ_q == 2'd0) & ~inflight_q;

  always_comb begin
    idle_cnt_d = '0;
    if (idle_cond) begin
      idle_cnt_d = (idle_cnt_q == HoldCnt) ? idle_cnt_q : idle_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_reset) begin
      rd_bin_q      <= '0;
      rd_ptr_gray_q <= '0;
      inflight_q    <= 1'b0;
      occ_q         <= 2'd0;
      idle_cnt_q    <= '0;
      rd_idle_q     <= 1'b0;
    end else begin
      rd_bin_q      <= rd_bin_d;
      rd_ptr_gray_q <= (AW+1)'(bin2gray(PTR_MAX_W'(rd_bin_d)));
      inflight_q    <= ram_re;
      occ_q         <= occ_d;
      idle_cnt_q    <= idle_cnt_d;
      rd_idle_q     <= (idle_cnt_d == HoldCnt);
    end
  end

  // Data registers carry no reset; occ_q qualifies them.
  always_ff @(posedge rd_clk) begin
    if (inflight_q && (occ_q == 2'd0 || (occ_q == 2'd1 && pop))) begin
      head_q <= rd_bus.ram_dout;
    end else if (pop && occ_q == 2'd2) begin
      head_q <= tail_q;
    end
    if (inflight_q && ((occ_q == 2'd1 && !pop) || (occ_q == 2'd2 && pop))) begin
      tail_q <= rd_bus.ram_dout;
    end
  end

  assign rd_bus.ram_re  = ram_re;
  assign rd_bus.ram_ra  = rd_bin_q[AW-1:0];
  assign rd_bus.rd_pvld = pvld;
  assign rd_bus.rd_pd   = head_q;

  assign rd_ptr_gray = rd_ptr_gray_q;
  assign rd_idle     = rd_idle_q;
  // Wake term bypasses the registered idle flag so a new write pointer ungates at once.
  assign rd_clk_en   = enable_r & (~rd_idle_q | (sync2 != rd_ptr_gray_q));

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed self-checking bench for async_fifo_rd_ctrl with a simple RAM and write-side model.
module tb_async_fifo_rd_ctrl;

  localparam int unsigned DEPTH     = 16;
  localparam int unsigned AW        = 4;
  localparam int unsigned DW        = 32;
  localparam int unsigned IDLE_HOLD = 4;

  logic          rd_clk = 1'b0;
  logic          rd_reset;
  logic          enable_r;
  logic [AW:0]   wr_ptr_gray;
  logic [AW:0]   rd_ptr_gray;
  logic [AW:0]   rd_count;
  logic          rd_idle;
  logic          rd_clk_en;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_bin;
  logic [DW-1:0] exp_q [$];
  int            seq = 0;
  int            reads_issued = 0;
  int            outstanding = 0;
  bit            overflow_seen = 1'b0;

  async_fifo_rd_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  async_fifo_rd_ctrl #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .DW       (DW),
    .IDLE_HOLD(IDLE_HOLD)
  ) dut (
    .rd_clk     (rd_clk),
    .rd_reset   (rd_reset),
    .wr_ptr_gray(wr_ptr_gray),
    .enable_r   (enable_r),
    .rd_bus     (bus),
    .rd_ptr_gray(rd_ptr_gray),
    .rd_count   (rd_count),
    .rd_idle    (rd_idle),
    .rd_clk_en  (rd_clk_en)
  );

  always #5 rd_clk = ~rd_clk;

  // RAM: data valid the cycle after the read strobe.
  always @(posedge rd_clk) begin
    if (bus.ram_re) bus.ram_dout <= mem[bus.ram_ra];
  end

  // Reads issued minus pops must never exceed the 2-entry buffer.
  always @(posedge rd_clk) begin
    if (rd_reset) begin
      outstanding <= 0;
    end else begin
      outstanding <= outstanding + (bus.ram_re ? 1 : 0) - ((bus.rd_pvld && bus.rd_prdy) ? 1 : 0);
      if (outstanding + (bus.ram_re ? 1 : 0) - ((bus.rd_pvld && bus.rd_prdy) ? 1 : 0) > 2)
        overflow_seen <= 1'b1;
      if (bus.ram_re) reads_issued <= reads_issued + 1;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge rd_clk);
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_bin[AW-1:0]] = 32'hC0DE_0000 + 32'(seq);
      exp_q.push_back(32'hC0DE_0000 + 32'(seq));
      seq++;
      wr_bin = wr_bin + 1'b1;
    end
    wr_ptr_gray = wr_bin ^ (wr_bin >> 1);
  endtask

  task automatic do_reset();
    @(negedge rd_clk);
    rd_reset    = 1'b1;
    enable_r    = 1'b1;
    bus.rd_prdy = 1'b0;
    wr_bin      = '0;
    wr_ptr_gray = '0;
    exp_q.delete();
    tick(2);
    reads_issued = 0;
    rd_reset = 1'b0;
  endtask

  // Pops up to n entries within budget cycles, counting data-order errors.
  task automatic drain(input int n, input int budget, output int got, output int bad);
    logic [DW-1:0] e;
    got = 0;
    bad = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      if (bus.rd_pvld && bus.rd_prdy) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        if (bus.rd_pd !== e) bad++;
        got++;
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.rd_pvld !== 1'b0) begin failures++;
      $display("FAIL reset_pvld: got %0b expected 0", bus.rd_pvld); end
    checks++; if (bus.ram_re !== 1'b0) begin failures++;
      $display("FAIL reset_ram_re: got %0b expected 0", bus.ram_re); end
    checks++; if (rd_ptr_gray !== 5'b00000) begin failures++;
      $display("FAIL reset_rd_ptr_gray: got %b expected 00000", rd_ptr_gray); end
    checks++; if (rd_count !== 5'd0) begin failures++;
      $display("FAIL reset_rd_count: got %0d expected 0", rd_count); end
    checks++; if (rd_idle !== 1'b0) begin failures++;
      $display("FAIL reset_rd_idle: got %0b expected 0", rd_idle); end
    checks++; if (rd_clk_en !== 1'b1) begin failures++;
      $display("FAIL reset_clk_en_on: got %0b expected 1", rd_clk_en); end
    enable_r = 1'b0;
    #1;
    checks++; if (rd_clk_en !== 1'b0) begin failures++;
      $display("FAIL reset_clk_en_off: got %0b expected 0", rd_clk_en); end
    enable_r = 1'b1;
  endtask

  task automatic test_single_entry();
    logic [DW-1:0] e;
    do_reset();
    bus.rd_prdy = 1'b1;
    push(1);
    e = exp_q[0];
    tick(1);
    checks++; if (bus.ram_re !== 1'b0) begin failures++;
      $display("FAIL single_re_early: got %0b expected 0", bus.ram_re); end
    tick(1);
    checks++; if (bus.ram_re !== 1'b1 || bus.ram_ra !== 4'd0) begin failures++;
      $display("FAIL single_re: got re=%0b ra=%0d expected re=1 ra=0", bus.ram_re, bus.ram_ra); end
    checks++; if (rd_count !== 5'd1) begin failures++;
      $display("FAIL single_count: got %0d expected 1", rd_count); end
    tick(1);
    checks++; if (bus.rd_pvld !== 1'b0 || rd_ptr_gray !== 5'b00001) begin failures++;
      $display("FAIL single_mid: got pvld=%0b ptr=%b expected pvld=0 ptr=00001",
               bus.rd_pvld, rd_ptr_gray); end
    tick(1);
    checks++; if (bus.rd_pvld !== 1'b1 || bus.rd_pd !== e) begin failures++;
      $display("FAIL single_data: got pvld=%0b pd=%h expected pvld=1 pd=%h",
               bus.rd_pvld, bus.rd_pd, e); end
    void'(exp_q.pop_front());
    tick(1);
    checks++; if (bus.rd_pvld !== 1'b0 || rd_ptr_gray !== 5'b00001 || rd_count !== 5'd0)
    begin failures++;
      $display("FAIL single_after_pop: got pvld=%0b ptr=%b count=%0d expected 0 00001 0",
               bus.rd_pvld, rd_ptr_gray, rd_count); end
  endtask

  // Expects the buffer to start producing within a few cycles and then deliver 16 back to back.
  task automatic stream16(input string tag, input logic [AW:0] exp_ptr);
    int waited = 0;
    int bubbles = 0;
    int bad = 0;
    logic [DW-1:0] e;
    while (!bus.rd_pvld && waited < 10) begin tick(1); waited++; end
    checks++; if (bus.rd_pvld !== 1'b1) begin failures++;
      $display("FAIL %s_first: no rd_pvld within 10 cycles, got %0b expected 1", tag,
               bus.rd_pvld); end
    for (int i = 0; i < 16; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      if (bus.rd_pvld !== 1'b1) bubbles++;
      else if (bus.rd_pd !== e) bad++;
      tick(1);
    end
    checks++; if (bubbles !== 0) begin failures++;
      $display("FAIL %s_bubbles: got %0d expected 0", tag, bubbles); end
    checks++; if (bad !== 0) begin failures++;
      $display("FAIL %s_order: got %0d bad entries expected 0", tag, bad); end
    checks++; if (bus.rd_pvld !== 1'b0 || rd_count !== 5'd0 || rd_ptr_gray !== exp_ptr)
    begin failures++;
      $display("FAIL %s_end: got pvld=%0b count=%0d ptr=%b expected 0 0 %b", tag,
               bus.rd_pvld, rd_count, rd_ptr_gray, exp_ptr); end
  endtask

  task automatic test_streaming();
    do_reset();
    bus.rd_prdy = 1'b1;
    push(16);
    stream16("stream", 5'b11000);
  endtask

  task automatic test_wrap();
    push(16);
    tick(2);
    checks++; if (rd_count !== 5'b10000) begin failures++;
      $display("FAIL wrap_full_count: got %b expected 10000", rd_count); end
    stream16("wrap", 5'b00000);
  endtask

  task automatic test_backpressure();
    int got, bad;
    do_reset();
    push(5);
    tick(8);
    checks++; if (reads_issued !== 2 || bus.ram_re !== 1'b0) begin failures++;
      $display("FAIL bp_reads: got reads=%0d re=%0b expected reads=2 re=0",
               reads_issued, bus.ram_re); end
    checks++; if (bus.rd_pvld !== 1'b1 || bus.rd_pd !== exp_q[0] || rd_count !== 5'd3)
    begin failures++;
      $display("FAIL bp_hold: got pvld=%0b pd=%h count=%0d expected 1 %h 3",
               bus.rd_pvld, bus.rd_pd, rd_count, exp_q[0]); end
    bus.rd_prdy = 1'b1;
    drain(5, 30, got, bad);
    checks++; if (got !== 5 || bad !== 0) begin failures++;
      $display("FAIL bp_release: got %0d entries %0d bad expected 5 entries 0 bad", got, bad); end
    checks++; if (overflow_seen !== 1'b0) begin failures++;
      $display("FAIL bp_overflow: got %0b expected 0", overflow_seen); end
  endtask

  task automatic test_idle_wake();
    int got, bad;
    do_reset();
    tick(3);
    checks++; if (rd_idle !== 1'b0 || rd_clk_en !== 1'b1) begin failures++;
      $display("FAIL idle_early: got idle=%0b en=%0b expected 0 1", rd_idle, rd_clk_en); end
    tick(1);
    checks++; if (rd_idle !== 1'b1 || rd_clk_en !== 1'b0) begin failures++;
      $display("FAIL idle_set: got idle=%0b en=%0b expected 1 0", rd_idle, rd_clk_en); end
    push(1);
    tick(1);
    checks++; if (rd_clk_en !== 1'b0) begin failures++;
      $display("FAIL wake_early: got en=%0b expected 0", rd_clk_en); end
    tick(1);
    checks++; if (rd_clk_en !== 1'b1 || rd_idle !== 1'b1 || bus.ram_re !== 1'b1) begin failures++;
      $display("FAIL wake_en: got en=%0b idle=%0b re=%0b expected 1 1 1",
               rd_clk_en, rd_idle, bus.ram_re); end
    tick(1);
    checks++; if (rd_idle !== 1'b0 || rd_clk_en !== 1'b1) begin failures++;
      $display("FAIL wake_idle_clr: got idle=%0b en=%0b expected 0 1", rd_idle, rd_clk_en); end
    bus.rd_prdy = 1'b1;
    drain(1, 10, got, bad);
    checks++; if (got !== 1 || bad !== 0) begin failures++;
      $display("FAIL wake_data: got %0d entries %0d bad expected 1 entry 0 bad", got, bad); end
  endtask

  task automatic test_test_mode();
    int got, bad;
    int waited = 0;
    do_reset();
    push(3);
    while (!bus.ram_re && waited < 10) begin tick(1); waited++; end
    tick(1);
    enable_r = 1'b0;
    tick(4);
    checks++; if (reads_issued !== 1 || bus.ram_re !== 1'b0 || rd_clk_en !== 1'b0)
    begin failures++;
      $display("FAIL tm_no_reads: got reads=%0d re=%0b en=%0b expected 1 0 0",
               reads_issued, bus.ram_re, rd_clk_en); end
    checks++; if (bus.rd_pvld !== 1'b1 || bus.rd_pd !== exp_q[0] || rd_count !== 5'd2)
    begin failures++;
      $display("FAIL tm_inflight: got pvld=%0b pd=%h count=%0d expected 1 %h 2",
               bus.rd_pvld, bus.rd_pd, rd_count, exp_q[0]); end
    bus.rd_prdy = 1'b1;
    void'(exp_q.pop_front());
    tick(1);
    checks++; if (bus.rd_pvld !== 1'b0 || reads_issued !== 1) begin failures++;
      $display("FAIL tm_pop: got pvld=%0b reads=%0d expected 0 1", bus.rd_pvld, reads_issued); end
    enable_r = 1'b1;
    drain(2, 20, got, bad);
    checks++; if (got !== 2 || bad !== 0) begin failures++;
      $display("FAIL tm_resume: got %0d entries %0d bad expected 2 entries 0 bad", got, bad); end
  endtask

  task automatic test_reset_midstream();
    int got, bad;
    int seen = 0;
    do_reset();
    push(5);
    tick(4);
    checks++; if (reads_issued !== 2 || bus.rd_pvld !== 1'b1) begin failures++;
      $display("FAIL mid_setup: got reads=%0d pvld=%0b expected 2 1",
               reads_issued, bus.rd_pvld); end
    rd_reset    = 1'b1;
    wr_bin      = '0;
    wr_ptr_gray = '0;
    exp_q.delete();
    tick(1);
    rd_reset = 1'b0;
    checks++; if (bus.rd_pvld !== 1'b0 || rd_ptr_gray !== 5'b00000 || bus.ram_re !== 1'b0)
    begin failures++;
      $display("FAIL mid_reset: got pvld=%0b ptr=%b re=%0b expected 0 00000 0",
               bus.rd_pvld, rd_ptr_gray, bus.ram_re); end
    for (int i = 0; i < 4; i++) begin
      if (bus.rd_pvld !== 1'b0) seen++;
      tick(1);
    end
    checks++; if (seen !== 0 || rd_count !== 5'd0) begin failures++;
      $display("FAIL mid_no_load: got %0d valid cycles count=%0d expected 0 0", seen, rd_count); end
    bus.rd_prdy = 1'b1;
    push(1);
    drain(1, 10, got, bad);
    checks++; if (got !== 1 || bad !== 0) begin failures++;
      $display("FAIL mid_recover: got %0d entries %0d bad expected 1 entry 0 bad", got, bad); end
  endtask

  initial begin
    rd_reset    = 1'b1;
    enable_r    = 1'b1;
    bus.rd_prdy = 1'b0;
    wr_bin      = '0;
    wr_ptr_gray = '0;
    test_reset();
    test_single_entry();
    test_streaming();
    test_wrap();
    test_backpressure();
    test_idle_wake();
    test_test_mode();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
